// File: rtl/eae_dvi_sequencer.sv
// eae_dvi_sequencer: EAE DVI control stage feeding the 24/12 restoring divider.
// Define EAE_DVI_WATCHDOG_EN to build the WAIT-state timeout (err on abort).
module eae_dvi_sequencer #(
  parameter int DIV_TIMEOUT = 32,
  parameter int QUIET_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        dvi_req,
  input  logic [11:0] pc_in,
  input  logic [11:0] ac_in,
  input  logic [11:0] mq_in,
  output logic        mem_rd_req,
  output logic [11:0] mem_addr,
  input  logic [11:0] mem_rd_data,
  input  logic        mem_rd_ack,
  output logic        div_start,
  output logic [23:0] div_dividend,
  output logic [11:0] div_divisor,
  input  logic [11:0] div_quotient,
  input  logic [11:0] div_remainder,
  input  logic        div_finished,
  output logic [11:0] ac_out,
  output logic [11:0] mq_out,
  output logic        link_out,
  output logic [11:0] pc_out,
  output logic        done,
  output logic        busy,
  output logic        err
);
  typedef enum logic [2:0] {QUIET, IDLE, FETCH, CHECK, START, WAIT, WB} state_t;
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYCLES - 1);
  state_t state, state_n;
  logic [QW-1:0] q_cnt;
  logic ovf, tmo;
  assign ovf = div_dividend[23:12] >= div_divisor;
`ifdef EAE_DVI_WATCHDOG_EN
  localparam int WW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(DIV_TIMEOUT - 1);
  logic [WW-1:0] w_cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) w_cnt <= '0;
    else w_cnt <= state == WAIT ? w_cnt + 1'b1 : '0;
  assign tmo = state == WAIT && !div_finished && w_cnt == W_LAST;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= QUIET;
    else state <= state_n;
  // the divider has no reset, so QUIET lets any in-flight division drain
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q_cnt <= '0;
    else if (state == QUIET) q_cnt <= q_cnt + 1'b1;
  always_comb begin
    state_n = state;
    case (state)
      QUIET:   state_n = q_cnt == Q_LAST ? IDLE : QUIET;
      IDLE:    state_n = dvi_req ? FETCH : IDLE;
      FETCH:   state_n = mem_rd_ack ? CHECK : FETCH;
      CHECK:   state_n = ovf ? WB : START;
      START:   state_n = WAIT;
      WAIT:    state_n = div_finished || tmo ? WB : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    mem_rd_req = state == FETCH;
    div_start  = state == START;
    done       = state == WB;
    busy       = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mem_addr     <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      ac_out       <= '0;
      mq_out       <= '0;
      link_out     <= 1'b0;
      pc_out       <= '0;
      err          <= 1'b0;
    end else begin
      if (state == IDLE && dvi_req) begin
        mem_addr     <= pc_in + 12'd1;
        div_dividend <= {ac_in, mq_in};
      end
      if (state == FETCH && mem_rd_ack) div_divisor <= mem_rd_data;
      // results land as WB is entered so they are valid alongside done
      if (state_n == WB) begin
        pc_out             <= mem_addr + 12'd1;
        err                <= tmo;
        link_out           <= state == CHECK;
        {ac_out, mq_out}   <= state == WAIT && div_finished ? {div_remainder, div_quotient} : div_dividend;
      end
    end
endmodule

// File: tb/tb_eae_dvi_sequencer.sv
// tb_eae_dvi_sequencer: directed checks of the DVI sequencer with a behavioural divider and memory.
module tb_eae_dvi_sequencer;
  logic        clock = 1'b0, reset_n = 1'b0, dvi_req = 1'b0;
  logic [11:0] pc_in = '0, ac_in = '0, mq_in = '0, mem_rd_data = '0;
  logic        mem_rd_ack = 1'b0, div_finished = 1'b0;
  logic [11:0] div_quotient = '0, div_remainder = '0;
  logic        mem_rd_req, div_start, link_out, done, busy, err;
  logic [11:0] mem_addr, div_divisor, ac_out, mq_out, pc_out;
  logic [23:0] div_dividend;
  int checks = 0, failures = 0;
  int lat, held, dc, starts, q_busy, q_req;
  logic [11:0] addr;

  eae_dvi_sequencer dut (
    .clock(clock), .reset_n(reset_n), .dvi_req(dvi_req), .pc_in(pc_in), .ac_in(ac_in), .mq_in(mq_in),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_ack(mem_rd_ack),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_finished(div_finished),
    .ac_out(ac_out), .mq_out(mq_out), .link_out(link_out), .pc_out(pc_out),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one DVI; memory acks after ack_dly cycles, divider finishes 13 cycles after div_start unless stalled.
  task automatic run_op(input logic [11:0] pc, input logic [11:0] ac, input logic [11:0] mq,
                        input logic [11:0] dvsr, input int ack_dly, input int limit, input bit stall,
                        output int o_lat, output logic [11:0] o_addr, output int o_held,
                        output int o_dc, output int o_starts);
    int st;
    logic [23:0] dd, qq, rr;
    dd = {ac, mq};
    qq = dvsr == 0 ? '0 : dd / {12'd0, dvsr};
    rr = dvsr == 0 ? '0 : dd % {12'd0, dvsr};
    dvi_req = 1'b1; pc_in = pc; ac_in = ac; mq_in = mq;
    o_lat = 0;
    while (!mem_rd_req && o_lat < 20) begin
      @(negedge clock);
      o_lat++;
    end
    dvi_req = 1'b0;
    o_addr = mem_addr;
    o_held = 0;
    repeat (ack_dly) begin
      o_held += int'(mem_rd_req);
      @(negedge clock);
    end
    mem_rd_ack = 1'b1; mem_rd_data = dvsr;
    o_dc = -1; o_starts = 0; st = -100;
    for (int c = 1; c <= limit && o_dc < 0; c++) begin
      @(negedge clock);
      mem_rd_ack = 1'b0; div_finished = 1'b0;
      if (div_start) begin o_starts++; st = c; end
      if (!stall && c == st + 13) begin
        div_finished = 1'b1; div_quotient = qq[11:0]; div_remainder = rr[11:0];
      end
      if (done) o_dc = c;
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1); chk("rst_req", mem_rd_req, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_acmq", {ac_out, mq_out}, 0); chk("rst_pc", pc_out, 0); chk("rst_done", done, 0);
    chk("rst_start", div_start, 0); chk("rst_err", err, 0);
    reset_n = 1'b1;
    repeat (16) @(negedge clock);
    chk("quiet_end_busy", busy, 0);

    run_op(12'o0200, 12'o0001, 12'o0000, 12'o0003, 0, 40, 0, lat, addr, held, dc, starts);
    chk("nrm_lat", lat, 1); chk("nrm_addr", addr, 12'o0201); chk("nrm_done_cyc", dc, 16);
    chk("nrm_starts", starts, 1); chk("nrm_mq", mq_out, 12'o2525); chk("nrm_ac", ac_out, 12'o0001);
    chk("nrm_link", link_out, 0); chk("nrm_pc", pc_out, 12'o0202); chk("nrm_err", err, 0);
    chk("nrm_dividend", div_dividend, 24'o00010000); chk("nrm_divisor", div_divisor, 12'o0003);
    @(negedge clock);
    chk("nrm_pulse", done, 0); chk("nrm_idle", busy, 0);

    run_op(12'o0100, 12'o0005, 12'o1234, 12'o0005, 0, 40, 0, lat, addr, held, dc, starts);
    chk("ovf_done_cyc", dc, 2); chk("ovf_starts", starts, 0); chk("ovf_link", link_out, 1);
    chk("ovf_ac", ac_out, 12'o0005); chk("ovf_mq", mq_out, 12'o1234); chk("ovf_pc", pc_out, 12'o0102);
    @(negedge clock);

    run_op(12'o0300, 12'o0000, 12'o0017, 12'o0000, 1, 40, 0, lat, addr, held, dc, starts);
    chk("dz_done_cyc", dc, 2); chk("dz_starts", starts, 0); chk("dz_link", link_out, 1);
    chk("dz_ac", ac_out, 12'o0000); chk("dz_mq", mq_out, 12'o0017);
    @(negedge clock);

    run_op(12'o7777, 12'o0002, 12'o0007, 12'o0010, 5, 40, 0, lat, addr, held, dc, starts);
    chk("wrap_addr", addr, 12'o0000); chk("wrap_held", held, 5); chk("wrap_done_cyc", dc, 16);
    chk("wrap_mq", mq_out, 12'o2000); chk("wrap_ac", ac_out, 12'o0007);
    chk("wrap_link", link_out, 0); chk("wrap_pc", pc_out, 12'o0001);
    @(negedge clock);

    run_op(12'o0500, 12'o0001, 12'o0000, 12'o0002, 0, 6, 1, lat, addr, held, dc, starts);
    chk("mid_starts", starts, 1); chk("mid_no_done", dc, -1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_acmq", {ac_out, mq_out}, 0); chk("mid_rst_pc", pc_out, 0); chk("mid_rst_link", link_out, 0);
    chk("mid_rst_busy", busy, 1); chk("mid_rst_dividend", div_dividend, 0); chk("mid_rst_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1; dvi_req = 1'b1;
    q_busy = 0; q_req = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      if (i <= 15) q_busy += int'(busy);
      q_req += int'(mem_rd_req);
    end
    chk("quiet_busy", q_busy, 15); chk("quiet_req", q_req, 0);
    run_op(12'o0400, 12'o0003, 12'o0000, 12'o0007, 0, 40, 0, lat, addr, held, dc, starts);
    chk("post_lat", lat, 1); chk("post_done_cyc", dc, 16);
    chk("post_mq", mq_out, 12'o3333); chk("post_ac", ac_out, 12'o0003); chk("post_pc", pc_out, 12'o0402);
    @(negedge clock);

    run_op(12'o1000, 12'o0001, 12'o0002, 12'o0100, 0, 60, 1, lat, addr, held, dc, starts);
`ifdef EAE_DVI_WATCHDOG_EN
    chk("wd_done_cyc", dc, 35); chk("wd_err", err, 1); chk("wd_ac", ac_out, 12'o0001);
    chk("wd_mq", mq_out, 12'o0002); chk("wd_link", link_out, 0);
`else
    chk("wd_no_done", dc, -1); chk("wd_err", err, 0); chk("wd_busy", busy, 1);
    chk("wd_hold_ac", ac_out, 12'o0003);
`endif
    reset_n = 1'b0;
    @(negedge clock);
    chk("end_err", err, 0); chk("end_busy", busy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
